// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU codes, funct3 enums, classes, FSM states.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Writeback source select
    localparam logic [2:0] RD_ALU   = 3'b000;
    localparam logic [2:0] RD_LOAD  = 3'b001;
    localparam logic [2:0] RD_LUI   = 3'b010;
    localparam logic [2:0] RD_PC4   = 3'b011;
    localparam logic [2:0] RD_PCIMM = 3'b100;

    // ALU operation code is {funct7[5], funct3}
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100, ALU_SRL = 4'b0101, ALU_OR  = 4'b0110, ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000, ALU_SRA = 4'b1101
    } alu_op_t;

    typedef enum logic [2:0] {F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010} store_f3_t;

    typedef enum logic [2:0] {
        F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LBU = 3'b100, F3_LHU = 3'b101
    } load_f3_t;

    typedef enum logic [2:0] {
        F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT  = 3'b100,
        F3_BGE = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111
    } branch_f3_t;

    typedef enum logic [3:0] {
        IC_R, IC_IALU, IC_LOAD, IC_STORE, IC_BRANCH, IC_LUI, IC_AUIPC, IC_JAL, IC_JALR, IC_ILL
    } iclass_t;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

endpackage

// File: rtl/rv32i_decode.sv
// Combinational RV32I classifier: instruction class, writeback info, ALU code, legality.
module rv32i_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] ir,
    output iclass_t     iclass,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [3:0]  alu_op,
    output logic [2:0]  rd_sel,
    output logic        rd_we,
    output logic        illegal
);
    logic [6:0] funct7;
    logic       unused_fields;

    assign rd            = ir[11:7];
    assign funct3        = ir[14:12];
    assign funct7        = ir[31:25];
    assign unused_fields = ^ir[24:15];

    // Classify by opcode and reject unsupported funct encodings
    always_comb begin
        iclass  = IC_ILL;
        alu_op  = ALU_ADD;
        rd_sel  = RD_ALU;
        rd_we   = 1'b0;
        illegal = 1'b0;
        case (ir[6:0])
            OP_R: begin
                iclass  = IC_R;
                alu_op  = {ir[30], funct3};
                rd_we   = 1'b1;
                illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
            end
            OP_IALU: begin
                iclass = IC_IALU;
                // only the shift-right form carries funct7[5] into the ALU code
                alu_op = {(funct3 == 3'b101) & ir[30], funct3};
                rd_we  = 1'b1;
                if (funct3 == 3'b001)
                    illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
            end
            OP_LOAD: begin
                iclass  = IC_LOAD;
                rd_sel  = RD_LOAD;
                rd_we   = 1'b1;
                illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
            end
            OP_STORE: begin
                iclass  = IC_STORE;
                illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
            end
            OP_BRANCH: begin
                iclass  = IC_BRANCH;
                alu_op  = ALU_SUB;
                illegal = (funct3 inside {3'b010, 3'b011});
            end
            OP_LUI:   begin iclass = IC_LUI;   rd_sel = RD_LUI;   rd_we = 1'b1; end
            OP_AUIPC: begin iclass = IC_AUIPC; rd_sel = RD_PCIMM; rd_we = 1'b1; end
            OP_JAL:   begin iclass = IC_JAL;   rd_sel = RD_PC4;   rd_we = 1'b1; end
            OP_JALR:  begin iclass = IC_JALR;  rd_sel = RD_PC4;   rd_we = 1'b1; end
            default:  illegal = 1'b1;
        endcase
        // an illegal instruction never writes the register file
        if (illegal) rd_we = 1'b0;
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle RV32I control FSM with fetch/data handshakes, wait timeout and trap state.
module multi_cycle_control #(
    parameter int MEM_TIMEOUT     = 16,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_rdata,
    output logic        instr_req,
    input  logic        instr_ready,
    output logic        data_req,
    input  logic        data_ready,
    input  logic        branch_taken,
    output logic        ir_write_en,
    output logic        pc_write_en,
    output logic [1:0]  pc_src,
    output logic        register_write_en,
    output logic        mem_write_en,
    output logic        imm_en,
    output logic [3:0]  alu_control_en,
    output logic [2:0]  S_type_data,
    output logic [2:0]  L_type_data,
    output logic [2:0]  B_type_data,
    output logic [2:0]  rd_mux_en,
    output logic        illegal_instr,
    output logic        bus_error,
    output logic        trapped
);
    import rv32i_pkg::*;

    // the wait cycle that lands on this count is the last one tolerated
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_next;
    logic [31:0] ir;
    logic [7:0]  wait_cnt;
    logic        started;
    logic        wait_bump;

    iclass_t     iclass;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic [2:0]  rd_sel;
    logic        rd_we;
    logic        illegal;

    rv32i_decode u_decode (
        .ir      (ir),
        .iclass  (iclass),
        .rd      (rd),
        .funct3  (funct3),
        .alu_op  (alu_op),
        .rd_sel  (rd_sel),
        .rd_we   (rd_we),
        .illegal (illegal)
    );

    // State, IR and wait counter; 'started' keeps instr_req low until the first clock out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            ir       <= NOP_INSTR;
            wait_cnt <= '0;
            started  <= 1'b0;
        end else begin
            state   <= state_next;
            started <= 1'b1;
            if (ir_write_en) ir <= instr_rdata;
            if (state_next != state) wait_cnt <= '0;
            else if (wait_bump)      wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Next state and strobes; ready inputs are only looked at in their own request state
    always_comb begin
        state_next        = state;
        wait_bump         = 1'b0;
        instr_req         = 1'b0;
        data_req          = 1'b0;
        ir_write_en       = 1'b0;
        pc_write_en       = 1'b0;
        pc_src            = 2'b00;
        register_write_en = 1'b0;
        mem_write_en      = 1'b0;
        imm_en            = 1'b0;
        alu_control_en    = 4'b0000;
        illegal_instr     = 1'b0;
        bus_error         = 1'b0;
        trapped           = 1'b0;
        case (state)
            S_FETCH: if (started) begin
                instr_req = 1'b1;
                if (instr_ready) begin
                    ir_write_en = 1'b1;
                    state_next  = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    bus_error  = 1'b1;
                    state_next = S_TRAP;
                end else begin
                    wait_bump = 1'b1;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    illegal_instr = 1'b1;
                    state_next    = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_WB;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_control_en = alu_op;
                imm_en         = (iclass != IC_R);
                case (iclass)
                    IC_LOAD, IC_STORE: state_next = S_MEM;
                    IC_BRANCH: begin
                        pc_write_en = 1'b1;
                        pc_src      = branch_taken ? 2'b01 : 2'b00;
                        state_next  = S_FETCH;
                    end
                    default: state_next = S_WB;
                endcase
            end
            S_MEM: begin
                data_req = 1'b1;
                if (data_ready) begin
                    if (iclass == IC_STORE) begin
                        // the write strobe marks the accepted beat only, so it fires once
                        mem_write_en = 1'b1;
                        pc_write_en  = 1'b1;
                        state_next   = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    bus_error  = 1'b1;
                    state_next = S_TRAP;
                end else begin
                    wait_bump = 1'b1;
                end
            end
            S_WB: begin
                register_write_en = rd_we && (rd != 5'd0);
                pc_write_en       = 1'b1;
                if (!illegal) begin
                    if (iclass == IC_JALR)     pc_src = 2'b10;
                    else if (iclass == IC_JAL) pc_src = 2'b01;
                end
                state_next = S_FETCH;
            end
            S_TRAP:  trapped = 1'b1;
            default: state_next = S_TRAP;
        endcase
    end

    // Instruction field outputs, only while a legal instruction is past decode
    always_comb begin
        rd_mux_en   = 3'b000;
        S_type_data = 3'b000;
        L_type_data = 3'b000;
        B_type_data = 3'b000;
        if ((state inside {S_EXEC, S_MEM, S_WB}) && !illegal) begin
            rd_mux_en = rd_sel;
            if (iclass == IC_STORE)  S_type_data = funct3;
            if (iclass == IC_LOAD)   L_type_data = funct3;
            if (iclass == IC_BRANCH) B_type_data = funct3;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: two instances (trap-on-illegal and NOP-on-illegal),
// table-driven instruction runs through a scoreboard queue, plus handshake corner cases.
module tb_multi_cycle_control;

    logic            clk = 1'b0;
    logic [1:0]      rst_n;
    logic [31:0]     instr_rdata;
    logic            instr_ready, data_ready, branch_taken;
    logic [1:0]      instr_req, data_req, ir_write_en, pc_write_en, register_write_en;
    logic [1:0]      mem_write_en, imm_en, illegal_instr, bus_error, trapped;
    logic [1:0][1:0] pc_src;
    logic [1:0][3:0] alu_control_en;
    logic [1:0][2:0] s_t, l_t, b_t, rd_mux_en;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        multi_cycle_control #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(g == 0 ? 1 : 0)) u_dut (
            .clk(clk), .rst_n(rst_n[g]), .instr_rdata(instr_rdata), .instr_req(instr_req[g]),
            .instr_ready(instr_ready), .data_req(data_req[g]), .data_ready(data_ready),
            .branch_taken(branch_taken), .ir_write_en(ir_write_en[g]),
            .pc_write_en(pc_write_en[g]), .pc_src(pc_src[g]),
            .register_write_en(register_write_en[g]), .mem_write_en(mem_write_en[g]),
            .imm_en(imm_en[g]), .alu_control_en(alu_control_en[g]), .S_type_data(s_t[g]),
            .L_type_data(l_t[g]), .B_type_data(b_t[g]), .rd_mux_en(rd_mux_en[g]),
            .illegal_instr(illegal_instr[g]), .bus_error(bus_error[g]), .trapped(trapped[g])
        );
    end

    typedef struct {
        string name; bit rst; int d; logic [31:0] ins; int iw, dw; bit bt, stray;
        int cyc, reg_n, mem_n, dreq, pcw, pc_src, rd_mux, f3, alu, ill, trap;
    } vec_t;

    typedef struct {
        int cyc, ir_n, reg_n, mem_n, dreq, pcw, pc_src, rd_mux, f3, alu, ill, trap, be;
        bit done;
    } obs_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    vec_t exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic vec_t mk(string nm, bit rst, int d, logic [31:0] ins, int iw, int dw,
                                bit bt, bit stray, int cyc, int reg_n, int mem_n, int dreq,
                                int pcw, int pc_src, int rd_mux, int f3, int alu, int ill,
                                int trap);
        vec_t v;
        v.name = nm; v.rst = rst; v.d = d; v.ins = ins; v.iw = iw; v.dw = dw; v.bt = bt;
        v.stray = stray; v.cyc = cyc; v.reg_n = reg_n; v.mem_n = mem_n; v.dreq = dreq;
        v.pcw = pcw; v.pc_src = pc_src; v.rd_mux = rd_mux; v.f3 = f3; v.alu = alu;
        v.ill = ill; v.trap = trap;
        return v;
    endfunction

    task automatic do_reset(input int d);
        @(negedge clk);
        instr_ready = 1'b0; data_ready = 1'b0;
        rst_n = 2'b00;
        repeat (2) @(negedge clk);
        rst_n[d] = 1'b1;
    endtask

    // One instruction: answer handshakes after the requested number of wait cycles and
    // observe strobes until the PC is written or the DUT traps.
    task automatic run(input int d, input logic [31:0] ins, input int iw, input int dw,
                       input bit bt, input bit stray, output obs_t o);
        int fw = 0, dc = 0;
        bit seen = 0;
        o = '{default: 0};
        for (int k = 0; k < 64 && !o.done; k++) begin
            @(negedge clk);
            instr_rdata  = ins;
            branch_taken = bt;
            instr_ready  = instr_req[d] ? (fw == iw) : stray;
            data_ready   = data_req[d]  ? (dc == dw) : stray;
            #1;
            if (instr_req[d]) seen = 1;
            if (seen) begin
                o.cyc++;
                if (o.cyc == iw + 3) o.alu = int'(alu_control_en[d]);
                o.ir_n  += int'(ir_write_en[d]);
                o.reg_n += int'(register_write_en[d]);
                o.mem_n += int'(mem_write_en[d]);
                o.dreq  += int'(data_req[d]);
                o.ill   += int'(illegal_instr[d]);
                o.be    += int'(bus_error[d]);
                if (instr_req[d]) fw++;
                if (data_req[d])  dc++;
                if (pc_write_en[d]) begin
                    o.pcw++;
                    o.pc_src = int'(pc_src[d]);
                    o.rd_mux = int'(rd_mux_en[d]);
                    o.f3     = int'(s_t[d] | l_t[d] | b_t[d]);
                    o.done   = 1;
                end
                if (trapped[d]) begin o.trap = 1; o.done = 1; end
            end
        end
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v, e;
        obs_t o;
        int   w, be_at, junk, ok;

        rst_n = 2'b00; instr_ready = 0; data_ready = 0; branch_taken = 0; instr_rdata = '0;

        //                  name   rst d  instr         iw dw bt st cyc rg mw dq pw ps rm f3 alu il tr
        tbl.push_back(mk("add",      0, 0, 32'h002081B3, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("sub",      0, 0, 32'h402081B3, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 8, 0, 0));
        tbl.push_back(mk("lw_wait3", 0, 0, 32'h0080A283, 0, 3, 0, 0, 8, 1, 0, 4, 1, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk("sw",       0, 0, 32'h0020A223, 0, 0, 0, 0, 4, 0, 1, 1, 1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk("sw_wait2", 0, 0, 32'h0020A223, 0, 2, 0, 0, 6, 0, 1, 3, 1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk("beq_tkn",  0, 0, 32'h00208463, 0, 0, 1, 0, 3, 0, 0, 0, 1, 1, 0, 0, -1, 0, 0));
        tbl.push_back(mk("beq_not",  0, 0, 32'h00208463, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, -1, 0, 0));
        tbl.push_back(mk("lui",      0, 0, 32'h123453B7, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk("auipc",    0, 0, 32'h00001417, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 4, 0, 0, 0, 0));
        tbl.push_back(mk("jal",      0, 0, 32'h010000EF, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk("jalr_x0",  0, 0, 32'h00008067, 0, 0, 0, 0, 4, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0));
        tbl.push_back(mk("nop_fw2",  0, 0, 32'h00000013, 2, 0, 0, 0, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("srai",     0, 0, 32'h4030D213, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 13, 0, 0));
        tbl.push_back(mk("andi",     0, 0, 32'h0050F313, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 7, 0, 0));
        tbl.push_back(mk("add_stray",0, 0, 32'h002081B3, 0, 0, 0, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("ill_trap", 1, 0, 32'h0000007F, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, -1, 1, 1));
        tbl.push_back(mk("badf7",    1, 0, 32'h022081B3, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, -1, 1, 1));
        tbl.push_back(mk("badbr",    1, 0, 32'h0020A463, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, -1, 1, 1));
        tbl.push_back(mk("ill_nop",  1, 1, 32'h0000007F, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, -1, 1, 0));
        tbl.push_back(mk("add_nopd", 0, 1, 32'h002081B3, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        // reset state, and instr_req held low until the first clock after release
        #3;
        chk("rst.strobes", int'({instr_req[0], data_req[0], ir_write_en[0], pc_write_en[0],
                                 register_write_en[0], mem_write_en[0], imm_en[0], trapped[0],
                                 illegal_instr[0], bus_error[0]}), 0);
        chk("rst.fields", int'({pc_src[0], alu_control_en[0], rd_mux_en[0]}), 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        #1 chk("rel.instr_req_low", int'(instr_req[0]), 0);
        @(negedge clk);
        #1 chk("rel.instr_req_high", int'(instr_req[0]), 1);

        foreach (tbl[i]) begin
            v = tbl[i];
            if (v.rst) do_reset(v.d);
            exp_q.push_back(v);
            run(v.d, v.ins, v.iw, v.dw, v.bt, v.stray, o);
            e = exp_q.pop_front();
            chk({e.name, ".done"},   int'(o.done), 1);
            chk({e.name, ".cycles"}, o.cyc,    e.cyc);
            chk({e.name, ".ir_wr"},  o.ir_n,   1);
            chk({e.name, ".reg_wr"}, o.reg_n,  e.reg_n);
            chk({e.name, ".mem_wr"}, o.mem_n,  e.mem_n);
            chk({e.name, ".dreq"},   o.dreq,   e.dreq);
            chk({e.name, ".pc_wr"},  o.pcw,    e.pcw);
            chk({e.name, ".pc_src"}, o.pc_src, e.pc_src);
            chk({e.name, ".rd_mux"}, o.rd_mux, e.rd_mux);
            chk({e.name, ".funct3"}, o.f3,     e.f3);
            if (e.alu >= 0) chk({e.name, ".alu"}, o.alu, e.alu);
            chk({e.name, ".illegal"}, o.ill,   e.ill);
            chk({e.name, ".trapped"}, o.trap,  e.trap);
            chk({e.name, ".bus_err"}, o.be,    0);
        end

        // fetch timeout: bus_error on the 16th wait cycle, then an absorbing trap
        do_reset(0);
        w = 0; be_at = -1; junk = 0;
        for (int k = 0; k < 40 && be_at < 0; k++) begin
            @(negedge clk);
            instr_ready = 1'b0;
            #1;
            if (instr_req[0]) w++;
            if (bus_error[0]) be_at = w;
        end
        chk("timeout.bus_error_cycle", be_at, 16);
        ok = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            instr_ready = 1'b1; data_ready = 1'b1;
            #1;
            if (!trapped[0]) ok = 0;
            junk += int'(instr_req[0]) + int'(data_req[0]) + int'(ir_write_en[0]) +
                    int'(pc_write_en[0]) + int'(register_write_en[0]) + int'(mem_write_en[0]) +
                    int'(bus_error[0]) + int'(illegal_instr[0]);
        end
        chk("trap.persists", ok, 1);
        chk("trap.quiet", junk, 0);

        // reset in the middle of a stalled store
        do_reset(0);
        w = 0; junk = 0;
        for (int k = 0; k < 20 && w < 2; k++) begin
            @(negedge clk);
            instr_rdata = 32'h0020A223;
            instr_ready = instr_req[0];
            data_ready  = 1'b0;
            #1;
            if (data_req[0]) w++;
            junk += int'(mem_write_en[0]);
        end
        chk("swrst.reached_mem", w, 2);
        rst_n[0] = 1'b0;
        #1;
        chk("swrst.data_req_drop", int'(data_req[0]), 0);
        chk("swrst.no_mem_wr", junk + int'(mem_write_en[0]) + int'(pc_write_en[0]), 0);
        chk("swrst.trap_clear", int'(trapped[0]), 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        #1 chk("swrst.instr_req_low", int'(instr_req[0]), 0);
        @(negedge clk);
        #1 chk("swrst.fetch_after", int'(instr_req[0]), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
